// File: rtl/aes_ctr_stream_ctrl.sv
// CTR-mode counter/keystream XOR stage and message framing around a combinational AES engine.
// Optional feature macro: AES_CTR_WRAP_ERR_EN (sticky counter-wrap error that abandons the message).
module aes_ctr_stream_ctrl #(
  parameter int unsigned CTR_W = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  output logic [127:0]     ctr_block,
  input  logic [127:0]     keystream,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             ctr_wrap_err
);

`ifdef AES_CTR_WRAP_ERR_EN
  localparam bit WRAP_ERR_EN = 1'b1;
`else
  localparam bit WRAP_ERR_EN = 1'b0;
`endif

  // Ones over the incrementing low part; the rest of the block is the fixed nonce.
  localparam logic [127:0] LOW_MASK = (CTR_W >= 128) ? '1 : ((128'd1 << CTR_W) - 128'd1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [127:0]     ctr_next;
  logic             accept;
  logic             drain;
  logic             wraps;
  logic             out_free;

  assign ctr_next = (ctr_block & ~LOW_MASK) | ((ctr_block + 128'd1) & LOW_MASK);
  assign wraps    = (ctr_block & LOW_MASK) == LOW_MASK;
  assign drain    = out_valid & out_ready;
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    in_ready = (state == RUN) && out_free && !ctr_wrap_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      done         <= 1'b0;
      ctr_block    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      ctr_wrap_err <= 1'b0;
    end else begin
      done <= 1'b0;
      // A drain and an accept in the same cycle leave out_valid set with the new block.
      if (drain) out_valid <= 1'b0;
      if (accept) begin
        out_data  <= in_data ^ keystream;
        out_valid <= 1'b1;
        out_last  <= (remaining == LEN_W'(1));
        ctr_block <= ctr_next;
        remaining <= remaining - LEN_W'(1);
        if (WRAP_ERR_EN && wraps) ctr_wrap_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            ctr_wrap_err <= 1'b0;
            if (num_blocks != '0) begin
              ctr_block <= iv;
              remaining <= num_blocks;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ctr_wrap_err) begin
            if (out_free) state <= IDLE;
          end else if (accept && remaining == LEN_W'(1)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // A wrapped message is abandoned once its pending block leaves, without done.
          if (ctr_wrap_err) begin
            if (out_free) state <= IDLE;
          end else if (drain && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Self-checking bench for aes_ctr_stream_ctrl with a stand-in keystream engine and a message-level model.
module tb_aes_ctr_stream_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] iv = '0;
  logic [15:0]  num_blocks = '0;
  logic         busy, done, in_ready, out_valid, out_last, ctr_wrap_err;
  logic [127:0] ctr_block, keystream, out_data;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  aes_ctr_stream_ctrl #(.CTR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .iv(iv), .num_blocks(num_blocks),
    .busy(busy), .done(done), .ctr_block(ctr_block), .keystream(keystream),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ctr_wrap_err(ctr_wrap_err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] V_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] V_IN0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] V_IN1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] V_OUT0 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] V_OUT1 = 128'h9806f66b7970fdff8617187bb9fffdff;

  // Stand-in for the AES-128 engine: exact for the reference vector's two counter blocks, a fixed mix elsewhere.
  function automatic logic [127:0] engine(input logic [127:0] c);
    if (c == V_IV) return V_IN0 ^ V_OUT0;
    if (c == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) return V_IN1 ^ V_OUT1;
    return c ^ {4{c[31:0] * 32'h9e3779b1}} ^ {c[95:0], c[127:96]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  always_comb keystream = engine(ctr_block);

  // Counter block for the k-th block of a message: low 32 bits advance mod 2^32, nonce untouched.
  function automatic logic [127:0] ctr_at(input logic [127:0] base, input int unsigned k);
    return {base[127:32], base[31:0] + k};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] feed_q[$];
  logic [127:0] sent_q[$];
  logic [127:0] acc_ctr_q[$];
  logic [127:0] got_data_q[$];
  logic         got_last_q[$];
  int unsigned  done_cnt, done_cyc, last_out_cyc, first_acc_cyc, last_acc_cyc;
  bit           busy_seen, ov_seen, err_seen, stall_bad, ready_bad, timed_out;

  // Drives one message and records what the DUT did; vmode/rmode: 0 = always, 1 = random, 2 = out_ready low 6 cycles.
  task automatic run_msg(input logic [127:0] iv_v, input int unsigned n, input int unsigned vmode,
                         input int unsigned rmode, input bit poke);
    int unsigned  cyc = 0;
    int unsigned  idle_cnt = 0;
    logic [127:0] cur, prev_data;
    bit           prev_stall = 1'b0;
    logic         prev_last = 1'b0;
    sent_q.delete(); acc_ctr_q.delete(); got_data_q.delete(); got_last_q.delete();
    done_cnt = 0; done_cyc = 0; last_out_cyc = 0; first_acc_cyc = 0; last_acc_cyc = 0;
    busy_seen = 0; ov_seen = 0; err_seen = 0; stall_bad = 0; ready_bad = 0; timed_out = 0;
    cur = (feed_q.size() != 0) ? feed_q.pop_front() : rand128();
    prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; iv = iv_v; num_blocks = n[15:0]; in_valid = 1'b0; out_ready = (rmode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    while (idle_cnt < 3) begin
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      in_valid = (sent_q.size() < n) && (vmode == 0 || $urandom_range(0, 1) == 1);
      in_data = cur;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (cyc >= 6);
      endcase
      if (poke) begin
        start = (cyc == 2);
        iv = ~iv_v;
        num_blocks = 16'd5;
      end
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stall_bad = 1;
      if (out_valid && !out_ready && in_ready) ready_bad = 1;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (busy) busy_seen = 1;
      if (out_valid) ov_seen = 1;
      if (ctr_wrap_err) err_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (sent_q.size() == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        sent_q.push_back(in_data);
        acc_ctr_q.push_back(ctr_block);
        cur = (feed_q.size() != 0) ? feed_q.pop_front() : rand128();
      end
      if (out_valid && out_ready) begin
        got_data_q.push_back(out_data);
        got_last_q.push_back(out_last);
        last_out_cyc = cyc;
      end
      idle_cnt = busy ? 0 : idle_cnt + 1;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, out_last, ctr_wrap_err, in_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, out_valid, out_last, ctr_wrap_err, in_ready});
    end
    checks++;
    if (ctr_block !== '0) begin failures++; $display("FAIL reset_ctr got=%h exp=0", ctr_block); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_vector(input int unsigned rmode, input string tag);
    feed_q.delete();
    feed_q.push_back(V_IN0);
    feed_q.push_back(V_IN1);
    run_msg(V_IV, 2, 0, rmode, 1'b0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL %s_timeout got=1 exp=0", tag); end
    checks++;
    if (got_data_q.size() != 2) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=2", tag, got_data_q.size());
    end else begin
      checks++;
      if (got_data_q[0] !== V_OUT0) begin failures++; $display("FAIL %s_out0 got=%h exp=%h", tag, got_data_q[0], V_OUT0); end
      checks++;
      if (got_data_q[1] !== V_OUT1) begin failures++; $display("FAIL %s_out1 got=%h exp=%h", tag, got_data_q[1], V_OUT1); end
      checks++;
      if ({got_last_q[0], got_last_q[1]} !== 2'b01) begin
        failures++;
        $display("FAIL %s_last got=%b%b exp=01", tag, got_last_q[0], got_last_q[1]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_out_cyc + 1) begin
      failures++;
      $display("FAIL %s_done got=cnt%0d@%0d exp=cnt1@%0d", tag, done_cnt, done_cyc, last_out_cyc + 1);
    end
    checks++;
    if (stall_bad || ready_bad) begin
      failures++;
      $display("FAIL %s_stall got=stall%0d/ready%0d exp=0/0", tag, stall_bad, ready_bad);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] wiv;
    wiv = 128'h00112233_44556677_8899aabb_ffffffff;
    run_msg(wiv, 2, 0, 0, 1'b0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL wrap_timeout got=1 exp=0"); end
`ifdef AES_CTR_WRAP_ERR_EN
    checks++;
    if (sent_q.size() != 1 || !err_seen || ctr_wrap_err !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err got=acc%0d/seen%0d/err%b exp=acc1/seen1/err1", sent_q.size(), err_seen, ctr_wrap_err);
    end
    checks++;
    if (ctr_block !== {wiv[127:32], 32'h0}) begin
      failures++;
      $display("FAIL wrap_ctr got=%h exp=%h", ctr_block, {wiv[127:32], 32'h0});
    end
    checks++;
    if (done_cnt != 0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_abandon got=done%0d/in_ready%b/busy%b exp=0/0/0", done_cnt, in_ready, busy);
    end
`else
    checks++;
    if (sent_q.size() != 2 || got_data_q.size() != 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d/%0d exp=2/2", sent_q.size(), got_data_q.size());
    end else begin
      checks++;
      if (acc_ctr_q[1] !== {wiv[127:32], 32'h0}) begin
        failures++;
        $display("FAIL wrap_ctr got=%h exp=%h", acc_ctr_q[1], {wiv[127:32], 32'h0});
      end
      checks++;
      if (got_data_q[1] !== (sent_q[1] ^ engine(ctr_at(wiv, 1)))) begin
        failures++;
        $display("FAIL wrap_data got=%h exp=%h", got_data_q[1], sent_q[1] ^ engine(ctr_at(wiv, 1)));
      end
    end
    checks++;
    if (err_seen || done_cnt != 1) begin
      failures++;
      $display("FAIL wrap_silent got=err%0d/done%0d exp=0/1", err_seen, done_cnt);
    end
`endif
  endtask

  task automatic test_zero_len();
    run_msg(rand128(), 0, 0, 0, 1'b0);
    checks++;
    if (busy_seen || ov_seen) begin
      failures++;
      $display("FAIL zero_len_idle got=busy%0d/ov%0d exp=0/0", busy_seen, ov_seen);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 0) begin
      failures++;
      $display("FAIL zero_len_done got=cnt%0d@%0d exp=cnt1@0", done_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] biv;
    biv = rand128();
    biv[31:28] = 4'h0;
    run_msg(biv, 6, 0, 0, 1'b0);
    checks++;
    if (sent_q.size() != 6 || last_acc_cyc - first_acc_cyc != 5) begin
      failures++;
      $display("FAIL b2b_rate got=acc%0d span%0d exp=acc6 span5", sent_q.size(), last_acc_cyc - first_acc_cyc);
    end
    checks++;
    if (err_seen || done_cnt != 1) begin
      failures++;
      $display("FAIL b2b_status got=err%0d/done%0d exp=0/1", err_seen, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] riv;
    @(posedge clk); #1;
    start = 1'b1; iv = rand128(); num_blocks = 16'd3; out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pending got=ov%b/busy%b exp=1/1", out_valid, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out_valid, out_last, ctr_wrap_err, in_ready} !== 6'b0 || ctr_block !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear got=%b/%h/%h exp=000000/0/0",
               {busy, done, out_valid, out_last, ctr_wrap_err, in_ready}, ctr_block, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    riv = rand128();
    riv[31:28] = 4'h0;
    run_msg(riv, 3, 1, 1, 1'b0);
    checks++;
    if (got_data_q.size() != 3 || acc_ctr_q.size() != 3 || done_cnt != 1) begin
      failures++;
      $display("FAIL rst_mid_rerun got=%0d/done%0d exp=3/done1", got_data_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_ctr_q[i] !== ctr_at(riv, i) || got_data_q[i] !== (sent_q[i] ^ engine(ctr_at(riv, i)))) begin
          failures++;
          $display("FAIL rst_mid_blk%0d got=%h exp=%h", i, got_data_q[i], sent_q[i] ^ engine(ctr_at(riv, i)));
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] siv;
    siv = rand128();
    siv[31:28] = 4'h0;
    run_msg(siv, 4, 0, 0, 1'b1);
    checks++;
    if (got_data_q.size() != 4 || sent_q.size() != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_start_count got=%0d/done%0d exp=4/done1", got_data_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_ctr_q[i] !== ctr_at(siv, i) || got_data_q[i] !== (sent_q[i] ^ engine(ctr_at(siv, i)))) begin
          failures++;
          $display("FAIL busy_start_blk%0d got=%h/%h exp=%h/%h", i, acc_ctr_q[i], got_data_q[i],
                   ctr_at(siv, i), sent_q[i] ^ engine(ctr_at(siv, i)));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] xiv;
    int unsigned  n;
    for (int m = 0; m < 6; m++) begin
      xiv = rand128();
      xiv[31:28] = 4'h0;
      n = $urandom_range(1, 8);
      run_msg(xiv, n, 1, 1, 1'b0);
      checks++;
      if (timed_out || got_data_q.size() != n || done_cnt != 1 || done_cyc != last_out_cyc + 1 || stall_bad || ready_bad) begin
        failures++;
        $display("FAIL rand%0d_frame got=to%0d/n%0d/done%0d@%0d/st%0d%0d exp=to0/n%0d/done1@%0d/st00",
                 m, timed_out, got_data_q.size(), done_cnt, done_cyc, stall_bad, ready_bad, n, last_out_cyc + 1);
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          checks++;
          if (got_data_q[i] !== (sent_q[i] ^ engine(ctr_at(xiv, i))) || got_last_q[i] !== (i == int'(n) - 1)) begin
            failures++;
            $display("FAIL rand%0d_blk%0d got=%h/%b exp=%h/%b", m, i, got_data_q[i], got_last_q[i],
                     sent_q[i] ^ engine(ctr_at(xiv, i)), (i == int'(n) - 1));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vector(0, "vector");
    test_vector(2, "backpressure");
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
